flash_reader: RTL

- Initiator for the byte-level flash port (ready/wr/din/format/dout). It is the counterpart of the flash model and the flash PHY.
- On a `start` pulse it issues fast-read 0x0B, a 24-bit address and one dummy byte, then fetches `len` bytes. Each byte is delivered on a valid/ready byte stream.
- Used by the boot loader and by CPU memory-mapped flash reads.

---
 rtl/flash_reader.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/flash_reader.sv
// ---------------------------------------------------------------------------
// flash_reader
//   Fast-read initiator for the byte-level flash port. A `start` request
//   issues 0x0B, a 24-bit address and one dummy byte, then clocks in `len`
//   data bytes. Each data byte is delivered on a valid/ready stream.
//
// Optional feature (macro STATUS_POLL_EN):
//   When defined, the read command is preceded by a status poll (0x05) that
//   repeats while status bit0 is set, followed by a CS# release.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start, addr, len    request (sampled only while idle)
//   busy, done, err     request status (done/err are one-cycle pulses)
//   m_valid, m_data,    output byte stream
//   m_ready
//   f_ready, f_wr,      flash byte port: f_wr only while f_ready=1,
//   f_din, f_format,    f_format=0 keeps CS# high
//   f_prescale, f_dout
// ---------------------------------------------------------------------------
module flash_reader #(
  parameter logic [2:0] FORMAT   = 3'b001,
  parameter logic [3:0] PRESCALE = 4'h0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  input  logic        f_ready,
  output logic        f_wr,
  output logic [7:0]  f_din,
  output logic [2:0]  f_format,
  output logic [3:0]  f_prescale,
  input  logic [7:0]  f_dout
);

  localparam logic [4:0] S_IDLE     = 5'd0;
  localparam logic [4:0] S_CMD      = 5'd1;
  localparam logic [4:0] S_A2       = 5'd2;
  localparam logic [4:0] S_A1       = 5'd3;
  localparam logic [4:0] S_A0       = 5'd4;
  localparam logic [4:0] S_DUMMY    = 5'd5;
  localparam logic [4:0] S_RD       = 5'd6;
  localparam logic [4:0] S_RD_WAIT  = 5'd7;
  localparam logic [4:0] S_CAP      = 5'd8;
  localparam logic [4:0] S_HOLD     = 5'd9;
  localparam logic [4:0] S_END      = 5'd10;
  localparam logic [4:0] S_END_WAIT = 5'd11;
  localparam logic [4:0] S_FINISH   = 5'd12;
  localparam logic [4:0] S_ABORT    = 5'd13;
`ifdef STATUS_POLL_EN
  localparam logic [4:0] S_ST_CMD     = 5'd14;
  localparam logic [4:0] S_ST_RD      = 5'd15;
  localparam logic [4:0] S_ST_RD_WAIT = 5'd16;
  localparam logic [4:0] S_ST_END     = 5'd17;
  localparam logic [4:0] S_FIRST      = S_ST_CMD;
`else
  localparam logic [4:0] S_FIRST      = S_CMD;
`endif

  // Last count value before the wait is declared lost.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [4:0]  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic [7:0]  f_din_q;
  logic [2:0]  f_format_q;
  logic        blank_q;

  logic        is_issue_s;
  logic        is_wait_s;
  logic        rdy_s;
  logic        wr_s;
  logic        waiting_s;
  logic        timeout_s;

  // Byte transmitted in a given state; address bytes come from the latch.
  function automatic logic [7:0] din_for(input logic [4:0] st, input logic [23:0] a);
    logic [7:0] d;
    case (st)
      S_CMD:      d = 8'h0B;
      S_A2:       d = a[23:16];
      S_A1:       d = a[15:8];
      S_A0:       d = a[7:0];
      S_END,
      S_END_WAIT: d = 8'hFF;
`ifdef STATUS_POLL_EN
      S_ST_CMD:   d = 8'h05;
      S_ST_END:   d = 8'hFF;
`endif
      default:    d = 8'h00;
    endcase
    return d;
  endfunction

  // Flash is selected (nonzero format) only while a command is in flight.
  function automatic logic [2:0] fmt_for(input logic [4:0] st);
    logic [2:0] f;
    case (st)
      S_CMD, S_A2, S_A1, S_A0, S_DUMMY,
      S_RD, S_RD_WAIT, S_CAP, S_HOLD: f = FORMAT;
`ifdef STATUS_POLL_EN
      S_ST_CMD, S_ST_RD, S_ST_RD_WAIT: f = FORMAT;
`endif
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  // Classify states: ones that transmit a byte and ones that only wait.
  always_comb begin
    is_issue_s = 1'b0;
    is_wait_s  = 1'b0;
    case (state_q)
      S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_RD, S_END: is_issue_s = 1'b1;
      S_RD_WAIT, S_END_WAIT:                          is_wait_s  = 1'b1;
`ifdef STATUS_POLL_EN
      S_ST_CMD, S_ST_RD, S_ST_END:                    is_issue_s = 1'b1;
      S_ST_RD_WAIT:                                   is_wait_s  = 1'b1;
`endif
      default: begin
        is_issue_s = 1'b0;
        is_wait_s  = 1'b0;
      end
    endcase
  end

  // f_ready is ignored in the blanking cycle right after a write.
  assign rdy_s     = f_ready & ~blank_q;
  // Gated directly by f_ready so a write never lands on a not-ready port.
  assign wr_s      = is_issue_s & rdy_s;
  assign waiting_s = (is_issue_s | is_wait_s) & ~blank_q & ~f_ready;
  assign timeout_s = waiting_s & (cnt_q == TMO_LAST);

  // Next-state and datapath logic of the request sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    // Counter runs only while waiting; any write or ready clears it.
    if (waiting_s) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          addr_d = addr;
          rem_d  = len;
          if (len == 16'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_FIRST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef STATUS_POLL_EN
      S_ST_CMD:     if (wr_s) state_d = S_ST_RD;      else state_d = state_q;
      S_ST_RD:      if (wr_s) state_d = S_ST_RD_WAIT; else state_d = state_q;
      S_ST_RD_WAIT: begin
        // Flash still busy (bit0 set): clock another status byte.
        if (rdy_s) begin
          if (f_dout[0]) state_d = S_ST_RD;
          else           state_d = S_ST_END;
        end else begin
          state_d = state_q;
        end
      end
      S_ST_END:     if (wr_s) state_d = S_CMD;        else state_d = state_q;
`endif
      S_CMD:      if (wr_s)  state_d = S_A2;       else state_d = state_q;
      S_A2:       if (wr_s)  state_d = S_A1;       else state_d = state_q;
      S_A1:       if (wr_s)  state_d = S_A0;       else state_d = state_q;
      S_A0:       if (wr_s)  state_d = S_DUMMY;    else state_d = state_q;
      S_DUMMY:    if (wr_s)  state_d = S_RD;       else state_d = state_q;
      S_RD:       if (wr_s)  state_d = S_RD_WAIT;  else state_d = state_q;
      S_RD_WAIT:  if (rdy_s) state_d = S_CAP;      else state_d = state_q;
      S_CAP: begin
        m_data_d  = f_dout;
        m_valid_d = 1'b1;
        rem_d     = rem_q - 16'd1;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        // No flash traffic here; the byte waits for the consumer.
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (rem_q != 16'd0) state_d = S_RD;
          else                state_d = S_END;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_END:      if (wr_s)  state_d = S_END_WAIT; else state_d = state_q;
      S_END_WAIT: if (rdy_s) state_d = S_FINISH;   else state_d = state_q;
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        done_d    = 1'b1;
        err_d     = 1'b1;
        busy_d    = 1'b0;
        m_valid_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        m_valid_d = 1'b0;
      end
    endcase

    if (timeout_s) begin
      state_d   = S_ABORT;
      m_valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and registered outputs; f_din/f_format follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 24'h000000;
      rem_q      <= 16'h0000;
      cnt_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 8'h00;
      f_din_q    <= 8'h00;
      f_format_q <= 3'b000;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      f_din_q    <= din_for(state_d, addr_d);
      f_format_q <= fmt_for(state_d);
      blank_q    <= wr_s;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign f_wr       = wr_s;
  assign f_din      = f_din_q;
  assign f_format   = f_format_q;
  assign f_prescale = PRESCALE;

endmodule
